// File: rtl/pwm_dac.sv
// pwm_dac: PWM audio DAC output stage.
// Once per 2^N-cycle period it pulses sample_req to advance the upstream
// sample counter and latches the presented sample as the next period's duty.
// Optional feature macro: PWM_DAC_DITHER_EN adds a 16-bit Galois LFSR that
// adds one LSB of dither to each latched sample, saturating at 2^N-1.
module pwm_dac #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         nRst,
  input  logic         en,
  input  logic [N-1:0] sample,
  output logic         sample_req,
  output logic         pwm_out,
  output logic         busy
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [N-1:0] CNT_MAX = {N{1'b1}};
  localparam logic [N-1:0] CNT_ONE = {{(N-1){1'b0}}, 1'b1};

  state_t         state_reg, state_next;
  logic [N-1:0]   cnt_reg, cnt_next;
  logic [N-1:0]   duty_reg, duty_next;
  logic [N-1:0]   latch_val;
  logic           period_end;

  // Last cycle of a running period: the only point where en is honoured in RUN.
  assign period_end = (state_reg == RUN) && (cnt_reg == CNT_MAX);

`ifdef PWM_DAC_DITHER_EN
  logic [15:0] lfsr_reg, lfsr_next;
  logic [N:0]  dith_sum;
  logic        latch_en;

  // An edge that loads duty: leaving IDLE, or continuing past a period end.
  assign latch_en  = en && ((state_reg == IDLE) || period_end);
  // One extra bit of headroom so the +1 dither can saturate instead of wrapping.
  assign dith_sum  = {1'b0, sample} + {{N{1'b0}}, lfsr_reg[0]};
  assign latch_val = dith_sum[N] ? CNT_MAX : dith_sum[N-1:0];

  // Galois LFSR advances only on latch edges so the dither sequence is per-sample.
  always_comb begin
    lfsr_next = lfsr_reg;
    if (latch_en) begin
      lfsr_next = {1'b0, lfsr_reg[15:1]} ^ (lfsr_reg[0] ? 16'hB400 : 16'h0000);
    end
  end

  // LFSR state register, seeded on reset.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      lfsr_reg <= 16'hACE1;
    end else begin
      lfsr_reg <= lfsr_next;
    end
  end
`else
  assign latch_val = sample;
`endif

  // State, period counter and duty registers.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      duty_reg  <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      duty_reg  <= duty_next;
    end
  end

  // Next-state logic and outputs; outputs depend only on registers plus en for the strobe.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    duty_next  = duty_reg;
    sample_req = 1'b0;
    pwm_out    = 1'b0;
    busy       = 1'b0;
    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (en) begin
          state_next = RUN;
          duty_next  = latch_val;
        end
      end
      RUN: begin
        busy     = 1'b1;
        pwm_out  = (cnt_reg < duty_reg);
        // Natural N-bit wrap takes the counter from 2^N-1 back to 0.
        cnt_next = cnt_reg + CNT_ONE;
        if (period_end) begin
          if (en) begin
            sample_req = 1'b1;
            duty_next  = latch_val;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_pwm_dac.sv
// tb_pwm_dac: scoreboard bench for pwm_dac (N=8).
// Stimulus runs period by period and pushes the expected duty/continuation
// of every period; an independent monitor measures each period from the pins.
module tb_pwm_dac;

  localparam int N = 8;
  localparam int P = 1 << N;

  logic         clk = 1'b0;
  logic         nRst;
  logic         en;
  logic [N-1:0] sample;
  logic         sample_req;
  logic         pwm_out;
  logic         busy;

  pwm_dac #(.N(N)) dut (
    .clk        (clk),
    .nRst       (nRst),
    .en         (en),
    .sample     (sample),
    .sample_req (sample_req),
    .pwm_out    (pwm_out),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int duty;
    bit cont;
  } exp_t;

  exp_t        exp_q[$];
  int          errors = 0;
  int          checks = 0;
  int          cur_duty = 0;
  bit          running = 0;
  logic [15:0] m_lfsr = 16'hACE1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference latch rule: the value that becomes the next period's duty.
  function automatic int model_latch(input logic [7:0] s);
`ifdef PWM_DAC_DITHER_EN
    int v;
    bit b;
    v = int'(s) + int'(m_lfsr[0]);
    if (v > P - 1) v = P - 1;
    b = m_lfsr[0];
    m_lfsr = m_lfsr >> 1;
    if (b) m_lfsr = m_lfsr ^ 16'hB400;
    return v;
`else
    return int'(s);
`endif
  endfunction

  // Monitor: measures each period seen on the pins and compares with the scoreboard.
  int mon_active = 0, mon_phase = 0, mon_highs = 0, mon_early = 0;
  int mon_last = 0, mon_bad = 0, mon_low = 0, chk_idle = 0;
  exp_t e;

  always @(negedge clk) begin
    if (!nRst) begin
      mon_active = 0;
      chk_idle   = 0;
    end else begin
      if (chk_idle != 0) begin
        check("busy_after_stop", int'(busy), 0);
        chk_idle = 0;
      end else if (mon_active == 0 && busy) begin
        mon_active = 1;
        mon_phase = 0; mon_highs = 0; mon_early = 0; mon_last = 0; mon_bad = 0; mon_low = 0;
      end
      if (mon_active != 0) begin
        if (!busy) mon_bad = 1;
        if (pwm_out) begin
          mon_highs++;
          if (mon_low != 0) mon_bad = 1;
        end else begin
          mon_low = 1;
        end
        if (sample_req) begin
          if (mon_phase == P - 1) mon_last = 1;
          else mon_early++;
        end
        if (mon_phase == P - 1) begin
          if (exp_q.size() == 0) begin
            check("scoreboard_underflow", 1, 0);
            mon_active = 0;
          end else begin
            e = exp_q.pop_front();
            check("period_high_cycles", mon_highs, e.duty);
            check("period_shape", mon_bad, 0);
            check("req_at_period_end", mon_last, int'(e.cont));
            check("req_mid_period", mon_early, 0);
            if (e.cont) begin
              mon_phase = 0; mon_highs = 0; mon_early = 0; mon_last = 0; mon_bad = 0; mon_low = 0;
            end else begin
              mon_active = 0;
              chk_idle = 1;
            end
          end
        end else begin
          mon_phase++;
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Raise en in IDLE; the closing edge latches s and enters RUN.
  task automatic start_run(input logic [7:0] s);
    en = 1'b1;
    sample = s;
    cur_duty = model_latch(s);
    tick();
    running = 1;
  endtask

  // Drive one full period; mode 0: en held, 1: en random, 2: en drops at cnt=100.
  task automatic run_period(input int mode, input bit rand_mid, input logic [7:0] s_end, input bit en_end);
    for (int k = 0; k < P - 1; k++) begin
      case (mode)
        1:       en = 1'($urandom_range(0, 1));
        2:       en = (k < 100);
        default: en = 1'b1;
      endcase
      sample = rand_mid ? 8'($urandom) : s_end;
      tick();
    end
    en = en_end;
    sample = s_end;
    exp_q.push_back('{cur_duty, en_end});
    if (en_end) cur_duty = model_latch(s_end);
    tick();
    running = en_end;
  endtask

  logic [7:0] up_val;

  initial begin
    nRst = 1'b0;
    en = 1'b0;
    sample = '0;
    repeat (3) tick();
    check("reset_outputs", int'({pwm_out, sample_req, busy}), 0);
    nRst = 1'b1;
    repeat (5) begin
      tick();
      check("idle_outputs", int'({pwm_out, sample_req, busy}), 0);
    end

    // Steady 0x40: 64 high / 192 low per period, one strobe per period.
    start_run(8'h40);
    for (int i = 0; i < 3; i++) run_period(0, 0, 8'h40, 1'b1);
    run_period(0, 0, 8'h40, 1'b0);

    // Duty extremes.
    start_run(8'h00);
    run_period(0, 0, 8'hFF, 1'b1);
    run_period(0, 0, 8'hFF, 1'b0);

    // Upstream advances on each strobe edge: duties 0x10,0x10,0x11,0x12.
    up_val = 8'h10;
    start_run(up_val);
    for (int i = 0; i < 4; i++) begin
      run_period(0, 0, up_val, i != 3);
      if (i != 3) up_val = up_val + 8'h01;
    end

    // en dropped mid-period: period completes, then a fresh latch on restart.
    start_run(8'h30);
    run_period(2, 1, 8'h77, 1'b0);
    start_run(8'h90);
    run_period(0, 0, 8'h21, 1'b0);

    // Randomised periods, samples and enable activity.
    for (int i = 0; i < 8; i++) begin
      if (!running) begin
        en = 1'b0;
        repeat ($urandom_range(1, 5)) tick();
        start_run(8'($urandom));
      end
      run_period(1, 1, 8'($urandom), $urandom_range(0, 3) != 0);
    end
    if (running) run_period(0, 0, 8'h55, 1'b0);
    en = 1'b0;
    repeat (4) tick();
    check("scoreboard_drained", exp_q.size(), 0);

    // Reset in the middle of a high phase.
    start_run(8'h80);
    repeat (50) tick();
    nRst = 1'b0;
    #1;
    check("async_reset_outputs", int'({pwm_out, sample_req, busy}), 0);
    exp_q.delete();
    m_lfsr = 16'hACE1;
    running = 0;
    en = 1'b0;
    tick();
    nRst = 1'b1;
    for (int i = 0; i < 600; i++) begin
      tick();
      check("idle_after_reset", int'({pwm_out, sample_req, busy}), 0);
    end

    // Restart after reset to confirm the reset duty/LFSR state.
    start_run(8'h40);
    run_period(0, 0, 8'h40, 1'b1);
    run_period(0, 0, 8'h40, 1'b0);
    repeat (4) tick();
    check("scoreboard_drained_end", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
